sample_readout: RTL and testbench

Drains captured samples out of the logic analyzer's circular sample RAM after a capture completes. Starting at the oldest sample address, it reads sequentially with wrap-around and serializes each `DATA_WIDTH` sample into bytes on a valid/ready byte stream toward the host-link transmitter. It is the read-side counterpart of the capture path that feeds the sample RAM through the input delay stage.

---
 rtl/sample_readout_pkg.sv | 18 +
 rtl/sample_readout_byte_serializer.sv | 54 +++++
 rtl/sample_readout.sv | 120 ++++++++++++
 tb/tb_sample_readout.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_readout_pkg.sv
// Shared definitions for the sample readout path.
//   SAMPLE_WIDTH : default width of one captured sample
//   IDLE..SEND   : readout FSM encodings, exported so status registers can decode them
//   bytes_for()  : bytes needed to carry a sample of a given width
package sample_readout_pkg;

   localparam int unsigned SAMPLE_WIDTH = 16;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] READ = 2'd1;
   localparam logic [1:0] LOAD = 2'd2;
   localparam logic [1:0] SEND = 2'd3;

   function automatic int unsigned bytes_for(input int unsigned width);
      return (width + 7) / 8;
   endfunction

endpackage

// File: rtl/sample_readout_byte_serializer.sv
// Serializes one sample word into bytes on a valid/ready stream, MSB byte first.
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   load         : capture word and start presenting byte 0 on the next cycle
//   word         : BYTES*8-bit zero-padded sample
//   tx_ready     : downstream accept
//   tx_data      : current byte (top byte of the shift register, so it is registered)
//   tx_valid     : tx_data valid, held until the last byte is accepted
//   last_accept  : the last byte of the word is being accepted this cycle
module sample_readout_byte_serializer #(
   parameter int unsigned BYTES = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic [BYTES*8-1:0] word,
   input  logic               tx_ready,
   output logic [7:0]         tx_data,
   output logic               tx_valid,
   output logic               last_accept
);

   localparam int unsigned W     = BYTES * 8;
   localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

   logic [W-1:0]     shreg;
   logic [IDX_W-1:0] idx;
   logic             accept;

   assign accept      = tx_valid && tx_ready;
   assign last_accept = accept && (idx == IDX_W'(BYTES - 1));
   assign tx_data     = shreg[W-1 -: 8];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shreg    <= '0;
         idx      <= '0;
         tx_valid <= 1'b0;
      end else if (load) begin
         shreg    <= word;
         idx      <= '0;
         tx_valid <= 1'b1;
      end else if (accept) begin
         shreg <= shreg << 8;
         if (last_accept) begin
            tx_valid <= 1'b0;
            idx      <= '0;
         end else begin
            idx <= idx + IDX_W'(1);
         end
      end
   end

endmodule

// File: rtl/sample_readout.sv
// Drains the circular sample RAM after a capture: reads num_samples words starting at
// start_addr (wrapping at the top of the RAM) and streams each one out as bytes.
// Ports:
//   clk, reset              : clock, asynchronous active-low reset
//   start                   : one-cycle dump request (ignored while busy)
//   start_addr, num_samples : oldest sample address and sample count, sampled with start
//   rd_en, rd_addr, rd_data : synchronous RAM read port (data one cycle after rd_en)
//   tx_data, tx_valid,
//   tx_ready                : byte stream toward the host-link transmitter
//   busy                    : dump in progress
//   done                    : one-cycle pulse when a dump completes
module sample_readout
   import sample_readout_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = SAMPLE_WIDTH,
   parameter int unsigned ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [ADDR_WIDTH:0]   num_samples,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned BYTES = bytes_for(DATA_WIDTH);
   localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH + 1)'(1);

   logic [1:0]            state;
   logic                  start_pend;  // request latched, acted on next cycle in IDLE
   logic [ADDR_WIDTH-1:0] addr;
   logic [ADDR_WIDTH:0]   remaining;
   logic                  load;
   logic [BYTES*8-1:0]    word;
   logic                  last_accept;

   assign load = (state == LOAD);

   always_comb begin
      word                   = '0;
      word[DATA_WIDTH-1:0]   = rd_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         start_pend <= 1'b0;
         addr       <= '0;
         remaining  <= '0;
         rd_en      <= 1'b0;
         rd_addr    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start_pend) begin
                  start_pend <= 1'b0;
                  if (remaining == '0) begin
                     done <= 1'b1;
                  end else begin
                     state   <= READ;
                     rd_en   <= 1'b1;
                     rd_addr <= addr;
                     busy    <= 1'b1;
                  end
               end else if (start) begin
                  start_pend <= 1'b1;
                  addr       <= start_addr;
                  remaining  <= num_samples;
               end
            end
            // RAM samples rd_en at the edge leaving READ; data is ready during LOAD.
            READ: begin
               rd_en <= 1'b0;
               state <= LOAD;
            end
            LOAD: state <= SEND;
            SEND: begin
               if (last_accept) begin
                  remaining <= remaining - CNT_ONE;
                  addr      <= addr + ADDR_WIDTH'(1);
                  if (remaining == CNT_ONE) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     state   <= READ;
                     rd_en   <= 1'b1;
                     rd_addr <= addr + ADDR_WIDTH'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   sample_readout_byte_serializer #(
      .BYTES(BYTES)
   ) u_ser (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .word       (word),
      .tx_ready   (tx_ready),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .last_accept(last_accept)
   );

endmodule

// File: tb/tb_sample_readout.sv
// Directed bench for sample_readout with a 16-bit, 256-word RAM model (RAM[i] = 16'h1000 + i).
module tb_sample_readout;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  start_addr = '0;
   logic [8:0]  num_samples = '0;
   logic        rd_en;
   logic [7:0]  rd_addr;
   logic [15:0] rd_data = '0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b1;
   logic        busy;
   logic        done;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int done_cnt = 0;
   int stab_err = 0;
   logic       stall_prev = 1'b0;
   logic [7:0] data_prev = '0;
   logic [7:0] got_bytes[$];
   logic [7:0] got_addrs[$];

   sample_readout #(
      .DATA_WIDTH(16),
      .ADDR_WIDTH(8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .start_addr (start_addr),
      .num_samples(num_samples),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   // RAM model and stream monitors; cyc holds the index of the latest edge.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rd_en) begin
         rd_data <= 16'h1000 + {8'h00, rd_addr};
         got_addrs.push_back(rd_addr);
      end
      if (tx_valid && tx_ready) got_bytes.push_back(tx_data);
      if (stall_prev && (!tx_valid || tx_data !== data_prev)) stab_err <= stab_err + 1;
      stall_prev <= tx_valid && !tx_ready;
      data_prev  <= tx_data;
      if (done) done_cnt <= done_cnt + 1;
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired at cyc=%0d want=finished", cyc);
      $fatal(1);
   end

   // Called 1 time unit after an edge; returns 1 after edge N (the edge sampling start).
   task automatic pulse_start(input logic [7:0] a, input logic [8:0] n, output int n_edge);
      start = 1'b1;
      start_addr = a;
      num_samples = n;
      @(posedge clk);
      #1;
      n_edge = cyc;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int m_edge);
      m_edge = -1;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            m_edge = cyc;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({rd_en, rd_addr, tx_data, tx_valid, busy, done} !== 20'h0) begin
         failures++;
         $display("FAIL reset_outputs got=%h want=0", {rd_en, rd_addr, tx_data, tx_valid, busy, done});
      end
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || rd_en !== 1'b0 || tx_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle got busy=%b rd_en=%b tx_valid=%b want=0,0,0", busy, rd_en, tx_valid);
      end
   endtask

   task automatic test_basic();
      int n, m, errs;
      logic [7:0] exp_b[6] = '{8'h10, 8'h05, 8'h10, 8'h06, 8'h10, 8'h07};
      logic [7:0] exp_a[3] = '{8'd5, 8'd6, 8'd7};
      got_bytes.delete();
      got_addrs.delete();
      tx_ready = 1'b1;
      pulse_start(8'd5, 9'd3, n);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL basic_busy_at_n got=%b want=0", busy);
      end
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b1 || rd_en !== 1'b1 || rd_addr !== 8'd5) begin
         failures++;
         $display("FAIL basic_n1 got busy=%b rd_en=%b rd_addr=%0d want=1,1,5", busy, rd_en, rd_addr);
      end
      @(posedge clk);
      #1;
      checks++;
      if (rd_en !== 1'b0 || tx_valid !== 1'b0) begin
         failures++;
         $display("FAIL basic_n2 got rd_en=%b tx_valid=%b want=0,0", rd_en, tx_valid);
      end
      @(posedge clk);
      #1;
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h10) begin
         failures++;
         $display("FAIL basic_n3 got tx_valid=%b tx_data=%h want=1,10", tx_valid, tx_data);
      end
      wait_done(40, m);
      checks++;
      if (m - n !== 13) begin
         failures++;
         $display("FAIL basic_done_edge got=%0d want=13 (edges after start edge)", m - n);
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL basic_busy_at_done got=%b want=0", busy);
      end
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL basic_done_pulse got=%b want=0", done);
      end
      errs = 0;
      if (got_bytes.size() != 6) errs++;
      else foreach (exp_b[i]) if (got_bytes[i] !== exp_b[i]) errs++;
      checks++;
      if (errs != 0) begin
         failures++;
         $display("FAIL basic_bytes got count=%0d bad=%0d want count=6 bad=0", got_bytes.size(), errs);
      end
      errs = 0;
      if (got_addrs.size() != 3) errs++;
      else foreach (exp_a[i]) if (got_addrs[i] !== exp_a[i]) errs++;
      checks++;
      if (errs != 0) begin
         failures++;
         $display("FAIL basic_addrs got count=%0d bad=%0d want count=3 bad=0", got_addrs.size(), errs);
      end
   endtask

   task automatic test_wrap();
      int n, m, errs;
      logic [7:0] exp_b[8] = '{8'h10, 8'hFE, 8'h10, 8'hFF, 8'h10, 8'h00, 8'h10, 8'h01};
      logic [7:0] exp_a[4] = '{8'd254, 8'd255, 8'd0, 8'd1};
      got_bytes.delete();
      got_addrs.delete();
      pulse_start(8'd254, 9'd4, n);
      wait_done(40, m);
      checks++;
      if (m - n !== 17) begin
         failures++;
         $display("FAIL wrap_done_edge got=%0d want=17", m - n);
      end
      errs = 0;
      if (got_addrs.size() != 4) errs++;
      else foreach (exp_a[i]) if (got_addrs[i] !== exp_a[i]) errs++;
      checks++;
      if (errs != 0) begin
         failures++;
         $display("FAIL wrap_addrs got count=%0d bad=%0d want count=4 bad=0", got_addrs.size(), errs);
      end
      errs = 0;
      if (got_bytes.size() != 8) errs++;
      else foreach (exp_b[i]) if (got_bytes[i] !== exp_b[i]) errs++;
      checks++;
      if (errs != 0) begin
         failures++;
         $display("FAIL wrap_bytes got count=%0d bad=%0d want count=8 bad=0", got_bytes.size(), errs);
      end
   endtask

   task automatic test_backpressure();
      int n, m, errs, stab0;
      logic [7:0] exp_b[4] = '{8'h10, 8'h05, 8'h10, 8'h06};
      got_bytes.delete();
      stab0 = stab_err;
      pulse_start(8'd5, 9'd2, n);
      m = -1;
      // Ready is high on edges N+1, N+4, N+7, ...
      for (int k = 0; k < 60; k++) begin
         tx_ready = (k % 3 == 0);
         @(posedge clk);
         #1;
         if (done) begin
            m = cyc;
            break;
         end
      end
      tx_ready = 1'b1;
      checks++;
      if (m - n !== 13) begin
         failures++;
         $display("FAIL bp_done_edge got=%0d want=13", m - n);
      end
      checks++;
      if (stab_err - stab0 !== 0) begin
         failures++;
         $display("FAIL bp_stable got unstable=%0d want=0", stab_err - stab0);
      end
      errs = 0;
      if (got_bytes.size() != 4) errs++;
      else foreach (exp_b[i]) if (got_bytes[i] !== exp_b[i]) errs++;
      checks++;
      if (errs != 0) begin
         failures++;
         $display("FAIL bp_bytes got count=%0d bad=%0d want count=4 bad=0", got_bytes.size(), errs);
      end
   endtask

   task automatic test_zero();
      int n;
      got_addrs.delete();
      pulse_start(8'd77, 9'd0, n);
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || rd_en !== 1'b0) begin
         failures++;
         $display("FAIL zero_n1 got done=%b busy=%b rd_en=%b want=1,0,0", done, busy, rd_en);
      end
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL zero_done_pulse got=%b want=0", done);
      end
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (got_addrs.size() != 0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL zero_no_read got reads=%0d busy=%b want=0,0", got_addrs.size(), busy);
      end
   endtask

   task automatic test_full();
      int n, m, errs;
      got_bytes.delete();
      got_addrs.delete();
      pulse_start(8'd10, 9'd256, n);
      wait_done(1100, m);
      checks++;
      if (m - n !== 1025) begin
         failures++;
         $display("FAIL full_done_edge got=%0d want=1025", m - n);
      end
      errs = 0;
      if (got_bytes.size() != 512) errs++;
      else begin
         for (int k = 0; k < 256; k++) begin
            if (got_bytes[2*k] !== 8'h10) errs++;
            if (got_bytes[2*k+1] !== 8'((10 + k) % 256)) errs++;
         end
      end
      checks++;
      if (errs != 0) begin
         failures++;
         $display("FAIL full_bytes got count=%0d bad=%0d want count=512 bad=0", got_bytes.size(), errs);
      end
      checks++;
      if (got_addrs.size() != 256 || got_addrs[0] !== 8'd10 || got_addrs[255] !== 8'd9) begin
         failures++;
         $display("FAIL full_addrs got count=%0d want count=256 first=10 last=9", got_addrs.size());
      end
   endtask

   task automatic test_start_busy();
      int n, m, errs;
      logic [7:0] exp_b[6] = '{8'h10, 8'h14, 8'h10, 8'h15, 8'h10, 8'h16};
      logic [7:0] exp_a[3] = '{8'd20, 8'd21, 8'd22};
      got_bytes.delete();
      got_addrs.delete();
      pulse_start(8'd20, 9'd3, n);
      repeat (4) @(posedge clk);
      #1;
      start = 1'b1;
      start_addr = 8'd100;
      num_samples = 9'd1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(40, m);
      checks++;
      if (m - n !== 13) begin
         failures++;
         $display("FAIL busy_start_done_edge got=%0d want=13", m - n);
      end
      repeat (6) @(posedge clk);
      #1;
      errs = 0;
      if (got_addrs.size() != 3) errs++;
      else foreach (exp_a[i]) if (got_addrs[i] !== exp_a[i]) errs++;
      checks++;
      if (errs != 0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL busy_start_addrs got count=%0d bad=%0d busy=%b want 3,0,0",
                  got_addrs.size(), errs, busy);
      end
      errs = 0;
      if (got_bytes.size() != 6) errs++;
      else foreach (exp_b[i]) if (got_bytes[i] !== exp_b[i]) errs++;
      checks++;
      if (errs != 0) begin
         failures++;
         $display("FAIL busy_start_bytes got count=%0d bad=%0d want count=6 bad=0",
                  got_bytes.size(), errs);
      end
   endtask

   task automatic test_reset_mid();
      int n, m, errs, done0;
      logic [7:0] exp_b[4] = '{8'h10, 8'h28, 8'h10, 8'h29};
      pulse_start(8'd30, 9'd3, n);
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h1E) begin
         failures++;
         $display("FAIL rmid_byte1 got tx_valid=%b tx_data=%h want=1,1e", tx_valid, tx_data);
      end
      done0 = done_cnt;
      reset = 1'b0;
      #1;
      checks++;
      if ({rd_en, rd_addr, tx_data, tx_valid, busy, done} !== 20'h0) begin
         failures++;
         $display("FAIL rmid_async_clear got=%h want=0", {rd_en, rd_addr, tx_data, tx_valid, busy, done});
      end
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || rd_en !== 1'b0 || tx_valid !== 1'b0 || done_cnt != done0) begin
         failures++;
         $display("FAIL rmid_after_release got busy=%b rd_en=%b tx_valid=%b dones=%0d want 0,0,0,0",
                  busy, rd_en, tx_valid, done_cnt - done0);
      end
      got_bytes.delete();
      pulse_start(8'd40, 9'd2, n);
      wait_done(40, m);
      checks++;
      if (m - n !== 9) begin
         failures++;
         $display("FAIL rmid_redump_done_edge got=%0d want=9", m - n);
      end
      errs = 0;
      if (got_bytes.size() != 4) errs++;
      else foreach (exp_b[i]) if (got_bytes[i] !== exp_b[i]) errs++;
      checks++;
      if (errs != 0) begin
         failures++;
         $display("FAIL rmid_redump_bytes got count=%0d bad=%0d want count=4 bad=0",
                  got_bytes.size(), errs);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_zero();
      test_full();
      test_start_busy();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
